// File: rtl/fp_pack.sv
// fp_pack: iterative normalizer + round-to-nearest-even packer producing an IEEE-754 word.
// Sign/exponent/extended significand in, packed word and status flags out, one op in flight.
package fp_pack_pkg;
  localparam int unsigned SNAN      = 0;
  localparam int unsigned QNAN      = 1;
  localparam int unsigned INFINITY  = 2;
  localparam int unsigned ZERO      = 3;
  localparam int unsigned SUBNORMAL = 4;
  localparam int unsigned NORMAL    = 5;
  localparam int unsigned LAST_FLAG = 6;
endpackage

module fp_pack
  import fp_pack_pkg::*;
#(
  parameter int unsigned NEXP = 5,
  parameter int unsigned NSIG = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic signed [NEXP+1:0] in_exp,
  input  logic [NSIG+3:0]        in_sig,
  input  logic                   in_sticky,
  input  logic [LAST_FLAG-1:0]   in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     f,
  output logic                   out_inexact,
  output logic                   out_overflow,
  output logic                   out_underflow
);

  localparam int unsigned SW   = NSIG + 4;
  localparam int unsigned EW   = NEXP + 3;
  localparam int unsigned CW   = $clog2(SW);
  localparam int          BIAS = (1 << (NEXP - 1)) - 1;

  localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX_E = EW'(BIAS);
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [CW-1:0]        CAP    = CW'(SW - 1);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_DENORM, S_ROUND, S_DONE} state_t;

  state_t                 state;
  logic                   sign_q;
  logic                   sticky_q;
  logic signed [EW-1:0]   exp_q;
  logic [SW-1:0]          sig_q;
  logic [CW-1:0]          cnt_q;

  logic                   guard, rbit, inc, carry, int_bit, inexact_r, ovf_r, tiny;
  logic [NSIG+1:0]        mant_r;
  logic [NSIG-1:0]        frac_r;
  logic signed [EW-1:0]   exp_r;
  logic [NEXP-1:0]        field_r;
  logic                   special;
  logic [NEXP+NSIG:0]     special_f;
  logic                   unused_flags;

  // RNE on the held significand; a carry out of the integer bit bumps the exponent.
  assign guard     = sig_q[1];
  assign rbit      = sig_q[0];
  assign inc       = guard & (rbit | sticky_q | sig_q[2]);
  assign mant_r    = {1'b0, sig_q[NSIG+2:2]} + (NSIG+2)'(inc);
  assign carry     = mant_r[NSIG+1];
  assign int_bit   = carry | mant_r[NSIG];
  assign frac_r    = carry ? mant_r[NSIG:1] : mant_r[NSIG-1:0];
  assign exp_r     = carry ? exp_q + ONE_E : exp_q;
  assign field_r   = int_bit ? NEXP'(exp_r + BIAS_E) : '0;
  assign inexact_r = guard | rbit | sticky_q;
  assign ovf_r     = int_bit & (exp_r > EMAX_E);
  assign tiny      = ~sig_q[NSIG+2];

  assign special      = in_flags[SNAN] | in_flags[QNAN] | in_flags[INFINITY] | in_flags[ZERO];
  assign unused_flags = ^in_flags;

  // NaN wins over infinity, infinity over zero.
  always_comb begin
    special_f = {in_sign, {(NEXP+NSIG){1'b0}}};
    if (in_flags[SNAN] | in_flags[QNAN])
      special_f = {in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
    else if (in_flags[INFINITY])
      special_f = {in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      f             <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      sign_q        <= 1'b0;
      sticky_q      <= 1'b0;
      exp_q         <= '0;
      sig_q         <= '0;
      cnt_q         <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          sign_q   <= in_sign;
          exp_q    <= EW'(in_exp);
          sig_q    <= in_sig;
          sticky_q <= in_sticky;
          cnt_q    <= '0;
          if (special) begin
            f             <= special_f;
            out_inexact   <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_valid     <= 1'b1;
            state         <= S_DONE;
          end else begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (sig_q[SW-1]) begin
            sig_q    <= {1'b0, sig_q[SW-1:1]};
            sticky_q <= sticky_q | sig_q[0];
            exp_q    <= exp_q + ONE_E;
          end else if (sig_q == '0) begin
            state <= S_ROUND;
          end else if (!sig_q[SW-2] && (exp_q > EMIN_E)) begin
            sig_q <= {sig_q[SW-2:0], 1'b0};
            exp_q <= exp_q - ONE_E;
          end else begin
            state <= S_DENORM;
          end
        end
        // Right-shift into the subnormal range; past the cap everything is already sticky.
        S_DENORM: begin
          if (exp_q < EMIN_E) begin
            if (cnt_q < CAP) begin
              sig_q    <= {1'b0, sig_q[SW-1:1]};
              sticky_q <= sticky_q | sig_q[0];
              exp_q    <= exp_q + ONE_E;
              cnt_q    <= cnt_q + CW'(1);
            end else begin
              sig_q    <= '0;
              sticky_q <= sticky_q | (|sig_q);
              exp_q    <= EMIN_E;
              state    <= S_ROUND;
            end
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (ovf_r) begin
            f             <= {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
            out_inexact   <= 1'b1;
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
          end else begin
            f             <= {sign_q, field_r, frac_r};
            out_inexact   <= inexact_r;
            out_overflow  <= 1'b0;
            out_underflow <= tiny & inexact_r;
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_pack.sv
// tb_fp_pack: directed corner cases plus randomized operations against an exact-arithmetic
// reference that rounds the true value (sticky treated as an infinitesimal above it).
module tb_fp_pack;
  import fp_pack_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_ready, in_sign, in_sticky;
  logic signed [6:0]     in_exp;
  logic [13:0]           in_sig;
  logic [LAST_FLAG-1:0]  in_flags;
  logic                  out_valid, out_ready;
  logic [15:0]           f;
  logic                  out_inexact, out_overflow, out_underflow;

  logic [LAST_FLAG-1:0]  fl_none, fl_snan, fl_qnan, fl_inf, fl_zero;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_sticky(in_sticky),
    .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .out_inexact(out_inexact), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Returns {f[15:0], inexact, overflow, underflow} for half precision.
  function automatic logic [18:0] model(input logic s, input int e, input logic [13:0] sg,
                                        input logic st, input logic [LAST_FLAG-1:0] fl);
    logic [127:0] x, q, rem, half;
    int p, ee, u;
    logic tiny, up, ix;
    if (fl[SNAN] || fl[QNAN]) return {s, 5'h1f, 1'b1, 9'h0, 3'b000};
    if (fl[INFINITY])         return {s, 5'h1f, 10'h0, 3'b000};
    if (fl[ZERO])             return {s, 15'h0, 3'b000};
    // x counts units of 2^-60: value = sg * 2^(e-12)
    x = 128'(sg) << (e + 48);
    if (x == '0) return {s, 15'h0, st, 1'b0, st};
    p = 0;
    for (int i = 0; i < 128; i++) if (x[i]) p = i;
    ee   = p - 60;
    tiny = (ee < -14);
    u    = tiny ? 36 : p - 10;
    q    = x >> u;
    rem  = x - (q << u);
    half = 128'(1) << (u - 1);
    up   = (rem > half) || ((rem == half) && (st || q[0]));
    ix   = (rem != '0) || st;
    q    = q + 128'(up);
    if (tiny) return {s, 15'(q), ix, 1'b0, ix};
    if (q == 128'd2048) begin
      q  = 128'd1024;
      ee = ee + 1;
    end
    if (ee > 15) return {s, 5'h1f, 10'h0, 3'b110};
    return {s, 5'(ee + 15), 10'(q - 128'd1024), ix, 2'b00};
  endfunction

  // Latency = rising edges after the accept edge until out_valid is seen.
  task automatic run_op(input logic s, input int e, input logic [13:0] sg, input logic st,
                        input logic [LAST_FLAG-1:0] fl, input int hold,
                        output logic [18:0] res, output int lat);
    int n;
    @(negedge clk);
    in_sign = s; in_exp = 7'(e); in_sig = sg; in_sticky = st; in_flags = fl; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    res = {f, out_inexact, out_overflow, out_underflow};
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold", 32'({out_valid, in_ready, f, out_inexact, out_overflow, out_underflow}),
          32'({1'b1, 1'b0, res}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("release", 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  task automatic directed(input string tag, input logic s, input int e, input logic [13:0] sg,
                          input logic st, input logic [LAST_FLAG-1:0] fl, input logic [15:0] fe,
                          input logic [2:0] fx, input int le, input int hold);
    logic [18:0] r;
    int lat;
    run_op(s, e, sg, st, fl, hold, r, lat);
    chk({tag, "_f"}, 32'(r[18:3]), 32'(fe));
    chk({tag, "_flags"}, 32'(r[2:0]), 32'(fx));
    if (le >= 0) chk({tag, "_lat"}, 32'(lat), 32'(le));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_sig = '0; in_sticky = 1'b0; in_flags = '0;
    fl_none = '0;
    fl_snan = '0; fl_snan[SNAN] = 1'b1;
    fl_qnan = '0; fl_qnan[QNAN] = 1'b1;
    fl_inf  = '0; fl_inf[INFINITY] = 1'b1;
    fl_zero = '0; fl_zero[ZERO] = 1'b1;

    #12;
    chk("rst_hs", 32'({in_ready, out_valid}), 32'(2'b10));
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_flags", 32'({out_inexact, out_overflow, out_underflow}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    //        tag        s   e    sig       st  flags    f        {ix,ov,uf} lat hold
    directed("one",      0,  0,   14'h1000, 0, fl_none, 16'h3C00, 3'b000,  3, 0);
    directed("tie_even", 0,  0,   14'h1006, 0, fl_none, 16'h3C02, 3'b100,  3, 1);
    directed("carry_in", 0,  0,   14'h2000, 0, fl_none, 16'h4000, 3'b000,  4, 0);
    directed("rnd_carry",0,  0,   14'h1FFE, 0, fl_none, 16'h4000, 3'b100,  3, 0);
    directed("left2",    0,  3,   14'h0400, 0, fl_none, 16'h4000, 3'b000,  5, 0);
    directed("ovf",      0,  16,  14'h1000, 0, fl_none, 16'h7C00, 3'b110,  3, 0);
    directed("ovf_rnd",  1,  15,  14'h1FFE, 0, fl_none, 16'hFC00, 3'b110,  3, 0);
    directed("sub_min",  0, -24,  14'h1000, 0, fl_none, 16'h0001, 3'b000, 13, 0);
    directed("sub_stk",  0, -24,  14'h1000, 1, fl_none, 16'h0001, 3'b101, 13, 0);
    directed("sub_up",   0, -15,  14'h1FFE, 0, fl_none, 16'h0400, 3'b101,  4, 0);
    directed("cap",      0, -60,  14'h1FFF, 0, fl_none, 16'h0000, 3'b101, 16, 0);
    directed("sig_zero", 1,  5,   14'h0000, 0, fl_none, 16'h8000, 3'b000, -1, 0);
    directed("qnan",     1,  0,   14'h1000, 1, fl_qnan, 16'hFE00, 3'b000,  0, 0);
    directed("snan",     0,  0,   14'h1000, 0, fl_snan | fl_zero, 16'h7E00, 3'b000, 0, 0);
    directed("inf",      1,  3,   14'h1234, 1, fl_inf,  16'hFC00, 3'b000,  0, 0);
    directed("zero",     1,  3,   14'h1234, 1, fl_zero, 16'h8000, 3'b000,  0, 0);
    directed("bp",       0,  0,   14'h1006, 0, fl_none, 16'h3C02, 3'b100,  3, 5);

    // Asynchronous reset while the normalizer is busy.
    @(negedge clk);
    in_sign = 1'b0; in_exp = -7'sd24; in_sig = 14'h1000; in_sticky = 1'b0;
    in_flags = fl_none; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_hs", 32'({in_ready, out_valid}), 32'(2'b10));
    chk("rst_mid_f", 32'(f), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("rst_mid_quiet", 32'({in_ready, out_valid}), 32'(2'b10));

    for (int k = 0; k < 300; k++) begin
      logic s, st;
      int e, lat;
      logic [13:0] sg;
      logic [LAST_FLAG-1:0] fl;
      logic [18:0] r, m;
      s = 1'($urandom);
      e = int'($urandom_range(58, 0)) - 40;
      case ($urandom_range(3, 0))
        0:       sg = 14'($urandom);
        1:       sg = {2'b01, 12'($urandom)};
        2:       sg = {1'b1, 13'($urandom)};
        default: sg = 14'($urandom) >> $urandom_range(13, 0);
      endcase
      st = 1'($urandom);
      fl = LAST_FLAG'($urandom);
      if ($urandom_range(7, 0) != 0) begin
        fl[SNAN] = 1'b0; fl[QNAN] = 1'b0; fl[INFINITY] = 1'b0; fl[ZERO] = 1'b0;
      end
      run_op(s, e, sg, st, fl, int'($urandom_range(2, 0)), r, lat);
      m = model(s, e, sg, st, fl);
      chk("rand_f", 32'(r[18:3]), 32'(m[18:3]));
      chk("rand_flags", 32'(r[2:0]), 32'(m[2:0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
